// File: rtl/clk_speed_cmp_n.sv
// ============================================================================
// clk_speed_cmp_n : N-channel clock-frequency meter; counts monitored-clock
//                   edges over a gated window, then ranks fastest/slowest.
// Rev 1.0
// ============================================================================
`default_nettype none

module clk_speed_cmp_n #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 16,
  parameter int SYNC_STAGES = 2,
  localparam int IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       mon_clk,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    cont,
  input  logic [WIN_W-1:0]        window_len,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic [NUM_CH-1:0]       ovf,
  output logic [IDX_W-1:0]        fastest_idx,
  output logic [IDX_W-1:0]        slowest_idx,
  output logic [NUM_CH-1:0]       faster_mask
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_COUNT   = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [NUM_CH-1:0]      w_edge;
  logic [WIN_W-1:0]       r_win_len;
  logic [WIN_W-1:0]       r_win;
  logic [CNT_W-1:0]       r_cnt [NUM_CH];
  logic [NUM_CH-1:0]      r_wovf;
  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       r_best;
  logic [IDX_W-1:0]       r_worst;
  logic [CNT_W-1:0]       r_best_cnt;
  logic [CNT_W-1:0]       r_worst_cnt;
  logic                   r_done;
  logic                   r_err;
  logic [NUM_CH*CNT_W-1:0] r_count;
  logic [NUM_CH-1:0]      r_ovf;
  logic [IDX_W-1:0]       r_fast;
  logic [IDX_W-1:0]       r_slow;
  logic [NUM_CH-1:0]      r_mask;
  logic                   w_req;

  // Per-channel synchronizer plus history flop; edge detect runs continuously.
  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_sync;
      logic                   r_hist;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_sync <= '0;
          r_hist <= 1'b0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], mon_clk[g]};
          r_hist <= r_sync[SYNC_STAGES-1];
        end
      end
      assign w_edge[g] = r_sync[SYNC_STAGES-1] & ~r_hist;
    end
  endgenerate

  assign w_req = start && !stop;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_req && (window_len != '0)) w_next = S_ARM;
      S_ARM:     w_next = stop ? S_IDLE : S_COUNT;
      S_COUNT:   if (stop) w_next = S_IDLE;
                 else if (r_win == WIN_W'(1)) w_next = S_COMPARE;
      S_COMPARE: if (stop) w_next = S_IDLE;
                 else if (r_idx == IDX_W'(NUM_CH-1)) w_next = S_DONE;
      S_DONE:    w_next = (cont && !stop) ? S_ARM : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_win_len   <= '0;
      r_win       <= '0;
      r_wovf      <= '0;
      r_idx       <= '0;
      r_best      <= '0;
      r_worst     <= '0;
      r_best_cnt  <= '0;
      r_worst_cnt <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_count     <= '0;
      r_ovf       <= '0;
      r_fast      <= '0;
      r_slow      <= '0;
      r_mask      <= '0;
      for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      r_err   <= (r_state == S_IDLE) && w_req && (window_len == '0);
      case (r_state)
        S_IDLE: if (w_req) r_win_len <= window_len;
        S_ARM: begin
          r_win  <= r_win_len;
          r_wovf <= '0;
          for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
        end
        S_COUNT: begin
          r_win <= r_win - WIN_W'(1);
          r_idx <= '0;
          for (int i = 0; i < NUM_CH; i++) begin
            if (w_edge[i]) begin
              if (&r_cnt[i]) r_wovf[i] <= 1'b1;
              else           r_cnt[i]  <= r_cnt[i] + CNT_W'(1);
            end
          end
        end
        S_COMPARE: begin
          // Strict comparisons keep the lowest index on ties.
          if ((r_idx == '0) || (r_cnt[r_idx] > r_best_cnt)) begin
            r_best     <= r_idx;
            r_best_cnt <= r_cnt[r_idx];
          end
          if ((r_idx == '0) || (r_cnt[r_idx] < r_worst_cnt)) begin
            r_worst     <= r_idx;
            r_worst_cnt <= r_cnt[r_idx];
          end
          r_idx <= r_idx + IDX_W'(1);
        end
        S_DONE: begin
          r_done <= 1'b1;
          r_ovf  <= r_wovf;
          r_fast <= r_best;
          r_slow <= r_worst;
          for (int i = 0; i < NUM_CH; i++) begin
            r_count[i*CNT_W +: CNT_W] <= r_cnt[i];
            r_mask[i]                 <= (r_cnt[i] > r_cnt[0]);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign err         = r_err;
  assign count       = r_count;
  assign ovf         = r_ovf;
  assign fastest_idx = r_fast;
  assign slowest_idx = r_slow;
  assign faster_mask = r_mask;

endmodule

`default_nettype wire
